// File: rtl/micro_seq_if.sv
// Program-load, run-control and issue bundle between a host and micro_seq.
// The master loads the program and starts runs; the slave drives the issue stream.
interface micro_seq_if;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [17:0] prog_wdata;
    logic        start;
    logic [7:0]  inst;
    logic [7:0]  data;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    modport master (
        output prog_we,
        output prog_addr,
        output prog_wdata,
        output start,
        input  inst,
        input  data,
        input  pc,
        input  busy,
        input  done
    );

    modport slave (
        input  prog_we,
        input  prog_addr,
        input  prog_wdata,
        input  start,
        output inst,
        output data,
        output pc,
        output busy,
        output done
    );
endinterface

// File: rtl/micro_seq.sv
// Micro-sequencer: 16-word program store that issues op/imm pairs to a core.
// Supports issue, jump, counted repeat and halt; all outputs registered.
module micro_seq (
    input  logic         clk,
    input  logic         rst,
    micro_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_REPEAT,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  inst_q, inst_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [17:0] mem_q [16];

    logic [17:0] word;
    logic [1:0]  ctl;
    logic [7:0]  op;
    logic [7:0]  imm;
    logic [7:0]  rep_n;
    logic        prog_ok;

    assign word  = mem_q[pc_q];
    assign ctl   = word[17:16];
    assign op    = word[15:8];
    assign imm   = word[7:0];
    assign rep_n = (imm == 8'd0) ? 8'd1 : imm;

    // Program loads only while the sequencer is not fetching.
    assign prog_ok = bus.prog_we && !rst &&
                     ((state_q == S_IDLE) || (state_q == S_HALT));

    always_ff @(posedge clk) begin
        if (prog_ok) begin
            mem_q[bus.prog_addr] <= bus.prog_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        data_d  = data_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                inst_d = 8'd0;
                data_d = 8'd0;
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = 4'd0;
                end
            end
            S_RUN: begin
                case (ctl)
                    2'b00: begin
                        inst_d = op;
                        data_d = imm;
                        pc_d   = pc_q + 4'd1;
                    end
                    2'b01: begin
                        inst_d = 8'd0;
                        data_d = 8'd0;
                        pc_d   = imm[3:0];
                    end
                    2'b10: begin
                        inst_d = op;
                        data_d = 8'd0;
                        if (rep_n == 8'd1) begin
                            pc_d = pc_q + 4'd1;
                        end else begin
                            cnt_d   = rep_n - 8'd1;
                            state_d = S_REPEAT;
                        end
                    end
                    default: begin
                        inst_d  = 8'd0;
                        data_d  = 8'd0;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_REPEAT: begin
                // Last held cycle advances past the repeat word.
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    pc_d    = pc_q + 4'd1;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_REPEAT);
        done_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            inst_q  <= 8'd0;
            data_q  <= 8'd0;
            pc_q    <= 4'd0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.inst = inst_q;
    assign bus.data = data_q;
    assign bus.pc   = pc_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_micro_seq.sv
// Scoreboard bench for micro_seq: expected issue stream queued per scenario.
// Each queued entry is the output snapshot expected after one clock edge.
module tb_micro_seq;

    typedef struct packed {
        logic [7:0] inst;
        logic [7:0] data;
        logic [3:0] pc;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];
    exp_t e;
    exp_t got;

    micro_seq_if bus ();

    micro_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic [7:0] i, input logic [7:0] d,
                                input logic [3:0] p, input logic b,
                                input logic dn);
        exp_t r;
        r.inst = i;
        r.data = d;
        r.pc   = p;
        r.busy = b;
        r.done = dn;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [17:0] w);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = a;
        bus.prog_wdata = w;
        step();
        bus.prog_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = 4'd0;
        bus.prog_wdata = 18'd0;
        step();
        step();
        got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
        checks++;
        if (got !== 22'd0) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", got, 22'd0);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
        checks++;
        if (got !== 22'd0) begin
            errors++;
            $display("FAIL idle_hold got=%h exp=%h", got, 22'd0);
        end
    endtask

    task automatic test_basic();
        int c;
        load(4'd0, {2'b00, 8'h12, 8'h55});
        load(4'd1, {2'b00, 8'h02, 8'h00});
        load(4'd2, {2'b11, 8'h00, 8'h00});
        bus.start = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h12, 8'h55, 4'd1, 1'b1, 1'b0));
        sb.push_back(mk(8'h02, 8'h00, 4'd2, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 4'd2, 1'b0, 1'b1));
        sb.push_back(mk(8'h00, 8'h00, 4'd2, 1'b0, 1'b1));
        c = 0;
        while (sb.size() > 0) begin
            step();
            bus.start = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL basic cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
    endtask

    task automatic test_repeat();
        int c;
        load(4'd0, {2'b10, 8'h48, 8'h03});
        load(4'd1, {2'b11, 8'h00, 8'h00});
        bus.start = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h48, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h48, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h48, 8'h00, 4'd1, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 4'd1, 1'b0, 1'b1));
        c = 0;
        while (sb.size() > 0) begin
            step();
            bus.start = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL repeat3 cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
        load(4'd0, {2'b10, 8'h48, 8'h00});
        bus.start = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h48, 8'h00, 4'd1, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 4'd1, 1'b0, 1'b1));
        c = 0;
        while (sb.size() > 0) begin
            step();
            bus.start = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL repeat0 cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
    endtask

    task automatic test_jump();
        int c;
        load(4'd0, {2'b00, 8'h08, 8'h0A});
        load(4'd1, {2'b01, 8'h00, 8'h00});
        bus.start = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(8'h08, 8'h0A, 4'd1, 1'b1, 1'b0));
            sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        end
        c = 0;
        while (sb.size() > 0) begin
            step();
            bus.start = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL jump cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
        checks++;
        if (got !== 22'd0) begin
            errors++;
            $display("FAIL jump_rst got=%h exp=%h", got, 22'd0);
        end
    endtask

    task automatic test_rst_repeat();
        int c;
        load(4'd0, {2'b10, 8'h5A, 8'h05});
        load(4'd1, {2'b00, 8'h33, 8'h44});
        load(4'd2, {2'b11, 8'h00, 8'h00});
        bus.start = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h5A, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h5A, 8'h00, 4'd0, 1'b1, 1'b0));
        c = 0;
        while (sb.size() > 0) begin
            step();
            bus.start = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rrep_pre cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
        checks++;
        if (got !== 22'd0) begin
            errors++;
            $display("FAIL rrep_rst got=%h exp=%h", got, 22'd0);
        end
        bus.start = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h5A, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h5A, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h5A, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h5A, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h5A, 8'h00, 4'd1, 1'b1, 1'b0));
        sb.push_back(mk(8'h33, 8'h44, 4'd2, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 4'd2, 1'b0, 1'b1));
        c = 0;
        while (sb.size() > 0) begin
            step();
            bus.start = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rrep_rerun cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
    endtask

    task automatic test_wrap();
        int c;
        logic [3:0] a;
        for (int k = 0; k < 16; k++) begin
            a = k[3:0];
            load(a, {2'b00, 4'h0, a, 8'h00});
        end
        bus.start = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        for (int k = 0; k < 20; k++) begin
            sb.push_back(mk({4'h0, 4'(k % 16)}, 8'h00, 4'((k + 1) % 16),
                            1'b1, 1'b0));
        end
        c = 0;
        while (sb.size() > 0) begin
            if (c == 5) begin
                bus.prog_we    = 1'b1;
                bus.prog_addr  = 4'd3;
                bus.prog_wdata = {2'b00, 8'hFF, 8'h00};
            end else begin
                bus.prog_we = 1'b0;
            end
            step();
            bus.start = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wrap cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
        bus.prog_we = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_halt_write();
        int c;
        load(4'd0, {2'b11, 8'h00, 8'h00});
        bus.start = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b1));
        c = 0;
        while (sb.size() > 0) begin
            step();
            bus.start = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL hw_halt cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 4'd0;
        bus.prog_wdata = {2'b00, 8'hAA, 8'hBB};
        bus.start      = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(8'hAA, 8'hBB, 4'd1, 1'b1, 1'b0));
        c = 0;
        while (sb.size() > 0) begin
            step();
            bus.start   = 1'b0;
            bus.prog_we = 1'b0;
            e   = sb.pop_front();
            got = {bus.inst, bus.data, bus.pc, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL hw_run cyc%0d got=%h exp=%h", c, got, e);
            end
            c++;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_basic();
        test_repeat();
        test_jump();
        test_rst_repeat();
        test_wrap();
        test_halt_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/micro_seq.md
MICRO_SEQ -- requirements
Module: micro_seq

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: prog_we  in  1  program-memory write enable.
REQ-004 SHALL have: prog_addr  in  4  program-memory write address.
REQ-005 SHALL have: prog_wdata  in  18  program word {ctl[17:16], op[15:8], imm[7:0]}.
REQ-006 SHALL have: start  in  1  run request, sampled each edge.
REQ-007 SHALL have: inst  out  8  instruction driven to the downstream micro core.
REQ-008 SHALL have: data  out  8  operand driven to the downstream core's data input.
REQ-009 SHALL have: pc  out  4  current fetch pointer.
REQ-010 SHALL have: busy  out  1  high in RUN or REPEAT.
REQ-011 SHALL have: done  out  1  high in HALT.

Function
REQ-012 Program memory SHALL be 16 x 18 bits, written at clock edges with prog_we=1 only in IDLE or HALT; writes in RUN/REPEAT SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, RUN, REPEAT, HALT; inst, data, pc, busy, done all registered.
REQ-014 IDLE: inst=0, data=0; start=1 -> RUN, pc<=0; no fetch on that edge.
REQ-015 RUN: each edge fetches mem[pc] and decodes ctl as REQ-016..019; first issue appears one edge after RUN entry (start-to-first-inst latency 2 edges).
REQ-016 ctl=00 ISSUE: inst<=op, data<=imm, pc<=pc+1 modulo 16 (15 wraps to 0).
REQ-017 ctl=01 JUMP: inst<=0, data<=0, pc<=imm[3:0]; jump to self legal (endless NOP loop, busy stays 1).
REQ-018 ctl=10 REPEAT: inst<=op, data<=0; op issued exactly N consecutive cycles, N=imm, imm=0 treated as 1; N=1 -> pc<=pc+1, stay RUN; N>1 -> cnt<=N-1, go REPEAT.
REQ-019 ctl=11 HALT: inst<=0, data<=0, pc unchanged, -> HALT.
REQ-020 REPEAT: inst/data held, cnt<=cnt-1 each edge; at the edge where cnt=1, pc<=pc+1 and -> RUN.
REQ-021 HALT: done=1, outputs 0; start=1 -> RUN, pc<=0, done<=0.
REQ-022 start SHALL be ignored in RUN and REPEAT.
REQ-023 prog_we and start on same IDLE/HALT edge: write SHALL complete; written word visible to first fetch.
REQ-024 cnt SHALL be 8 bits, never underflow; all pc arithmetic 4-bit wrapping.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, inst=0, data=0, pc=0, cnt=0, busy=0, done=0, from any state incl. mid-REPEAT; rst dominates start and prog_we.
REQ-026 Program memory contents SHALL NOT be cleared by rst.

Verification
REQ-027 mem0={00,12,55}, mem1={00,02,00}, mem2={11,00,00}; pulse start -> inst/data 12/55, then 02/00, then 00/00 with done=1, busy=0.
REQ-028 mem0={10,48,03}, mem1={11,..} -> inst=48 data=00 exactly 3 cycles, then 00, done=1; repeat with imm=00 -> exactly 1 cycle.
REQ-029 mem0={00,08,0A}, mem1={01,00,00} -> inst alternates 08,00,08,00...; pc alternates 1,0; busy=1 throughout.
REQ-030 rst during 2nd cycle of a 5-count REPEAT -> next edge inst=0, data=0, pc=0, busy=0, done=0; start reruns identical sequence (memory retained).
REQ-031 All 16 words {00,op=addr,00}, no halt -> inst 00..0F then 00 again (pc wrap); prog_we to addr 3 during run -> word 3 unchanged on next pass.
REQ-032 From HALT: prog_we addr0 {00,AA,BB} with start same edge -> first issue AA/BB, done drops.
